led_seq: RTL and testbench
==========================

LED_SEQ -- requirements
Module: led_seq

Interface
- REQ-001 Parameter WIDTH, default 8: LED vector width, minimum 2.
- REQ-002 clk_i  input  1  system clock (50 MHz board clock).
- REQ-003 rst_i  input  1  reset, synchronous, active-high.
- REQ-004 tick_i  input  1  divided-clock level from the frequency divider, generated in the clk_i domain.
- REQ-005 en_i  input  1  step enable; 0 freezes the pattern.
- REQ-006 mode_i  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count-up.
- REQ-007 led_o  output  WIDTH  registered LED pattern.
- REQ-008 step_o  output  1  one-cycle pulse, high in the cycle led_o changes.

Function
- REQ-009 Step event: tick_i sampled 1 in the current clk_i cycle and 0 in the previous cycle (rising edge); the falling edge and a constant level shall not step.
- REQ-010 On a step event with en_i=1, led_o shall update at that same clk_i edge (one cycle after tick_i rises at the input register) and step_o shall be 1 for exactly that one cycle.
- REQ-011 Step events with en_i=0 shall be discarded and not queued; led_o and the bounce state shall hold.
- REQ-012 Mode 0: led_o rotates left by 1; MSB wraps to LSB.
- REQ-013 Mode 1: led_o rotates right by 1; LSB wraps to MSB.
- REQ-014 Mode 2: two-state FSM GO_LEFT/GO_RIGHT. In GO_LEFT, shift left; on reaching the MSB, change to GO_RIGHT. In GO_RIGHT, shift right; on reaching the LSB, change to GO_LEFT. A single lit bit never leaves the vector.
- REQ-015 Mode 3: led_o = led_o + 1 modulo 2^WIDTH; all-ones wraps to 0.
- REQ-016 mode_i is registered at every step event; if it differs from the previously registered mode, that step loads the new mode's initial pattern instead of advancing. Initial patterns: mode 0 and 2 = 1 (LSB), mode 1 = MSB only, mode 3 = 0. Bounce FSM is set to GO_LEFT.
- REQ-017 mode_i changes between step events shall have no effect until the next step event.
- REQ-018 Entering mode 2 from a multi-bit pattern is impossible, because of REQ-016; led_o shall always be one-hot in modes 0–2.

Reset
- REQ-019 With rst_i=1 at a clk_i edge: led_o = 1, step_o = 0, registered mode = 0, FSM = GO_LEFT.
- REQ-020 The previous-tick register shall reset to 1, so that tick_i high at reset release produces no step.
- REQ-021 Reset shall override a simultaneous step event and take effect mid-pattern in any mode.

Configuration
- REQ-022 Macro LED_SEQ_INVERT_EN: when defined, led_o shall drive the bitwise inverse of the internal pattern (active-low LEDs), including the reset value all-ones except bit 0. When undefined, led_o shall drive the pattern directly. step_o is unaffected either way.

Structure
- REQ-023 Shared package led_seq_pkg shall hold the mode encodings (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_COUNT) and the bounce state encodings.
- REQ-024 Sub-module edge_det shall implement the rising-edge detector of REQ-009 and REQ-020 (clk_i, rst_i, d_i, rise_o).

Verification
- REQ-025 Reset, then mode 0 with en_i=1 and 9 tick rises -> led_o goes 02,04,...,80,01; exactly 9 step_o pulses of one cycle each.
- REQ-026 Mode 2 with 16 rises starting from 01 -> led_o goes 02..80, then 40..01, then 02; the direction reverses only at 80 and 01.
- REQ-027 Mode 3 from FE with 3 rises -> FF, 00, 01; en_i=0 over 2 rises -> led_o holds and step_o stays 0.
- REQ-028 In mode 0 at 08, change mode_i to 1 between ticks -> no change until the next rise; that rise gives 80, and the following rise gives 40.
- REQ-029 tick_i held high through reset release -> no step; tick_i held high for 100 cycles -> exactly one step; rst_i asserted during a step event -> led_o = 01, step_o = 0.
- REQ-030 Build with LED_SEQ_INVERT_EN defined, then repeat REQ-025 -> led_o = FE after reset and FD after the first step.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: pattern mode encodings, bounce direction encodings.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROL    = 2'd0,
      MODE_ROR    = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   typedef enum logic {
      GO_LEFT  = 1'b0,
      GO_RIGHT = 1'b1
   } dir_e;

endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: groups the sequencer control inputs and LED outputs.
// Latency: n/a (wiring only).
// Backpressure: none; tick-driven, outputs always valid.
// Signals: tick_i, en_i, mode_i (to sequencer); led_o, step_o (from sequencer).
// Modports: master = stimulus/controller side, slave = led_seq.
interface led_seq_if #(
   parameter int WIDTH = 8
);

   logic             tick_i;
   logic             en_i;
   logic [1:0]       mode_i;
   logic [WIDTH-1:0] led_o;
   logic             step_o;

   modport master (output tick_i, output en_i, output mode_i,
                   input  led_o,  input  step_o);

   modport slave  (input  tick_i, input  en_i, input  mode_i,
                   output led_o,  output step_o);

endinterface

// File: rtl/led_seq_edge_det.sv
// edge_det: rising-edge detector for a level generated in the clk_i domain.
// Latency: rise_o is combinational from d_i in the cycle d_i first reads 1.
// Backpressure: none.
// Ports: clk_i, rst_i (sync, active-high), d_i level in, rise_o pulse out.
module edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic prev_q;

   // Resetting the history to 1 means a level already high at reset
   // release looks like "no change" rather than a fresh edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= d_i;
      end
   end

   assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/led_seq.sv
// led_seq: tick-stepped LED pattern generator (rotate-left/right, bounce, count).
// Latency: led_o/step_o update at the clk_i edge that samples a tick_i rise.
// Backpressure: none; ticks arriving with en_i=0 are dropped, never queued.
// Ports: clk_i, rst_i (sync, active-high), bus (led_seq_if.slave).
// Build option: LED_SEQ_INVERT_EN drives led_o as the inverse of the pattern.
module led_seq
   import led_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   led_seq_if.slave   bus
);

   localparam logic [WIDTH-1:0] PAT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PAT_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   logic             rise;
   logic [WIDTH-1:0] pat_q, pat_d;
   mode_e            mode_q, mode_d, mode_in;
   dir_e             dir_q, dir_d;
   logic             step_q, step_d;

   edge_det u_edge_det (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (bus.tick_i),
      .rise_o (rise)
   );

   assign mode_in = mode_e'(bus.mode_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pat_q  <= PAT_LSB;
         mode_q <= MODE_ROL;
         dir_q  <= GO_LEFT;
         step_q <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         step_q <= step_d;
      end
   end

   always_comb begin
      pat_d  = pat_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      if (rise && bus.en_i) begin
         step_d = 1'b1;
         mode_d = mode_in;
         if (mode_in != mode_q) begin
            // A mode switch spends its step loading the new start pattern,
            // which is what keeps bounce mode one-hot.
            dir_d = GO_LEFT;
            case (mode_in)
               MODE_ROL, MODE_BOUNCE: pat_d = PAT_LSB;
               MODE_ROR:              pat_d = PAT_MSB;
               default:               pat_d = '0;
            endcase
         end else begin
            case (mode_q)
               MODE_ROL: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
               MODE_ROR: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
               MODE_BOUNCE: begin
                  // Direction flips on arrival at an end, so the next
                  // step already moves back inward.
                  if (dir_q == GO_LEFT) begin
                     pat_d = pat_q << 1;
                     if (pat_d[WIDTH-1]) dir_d = GO_RIGHT;
                  end else begin
                     pat_d = pat_q >> 1;
                     if (pat_d[0]) dir_d = GO_LEFT;
                  end
               end
               default: pat_d = pat_q + PAT_LSB;
            endcase
         end
      end
   end

`ifdef LED_SEQ_INVERT_EN
   assign bus.led_o = ~pat_q;
`else
   assign bus.led_o = pat_q;
`endif
   assign bus.step_o = step_q;

endmodule

// File: tb/tb_led_seq.sv
// tb_led_seq: directed, table-driven check of led_seq.
// Latency: expects led_o/step_o one edge after the tick_i rise is driven.
// Backpressure: n/a.
module tb_led_seq;

   localparam int W = 8;
`ifdef LED_SEQ_INVERT_EN
   localparam logic [W-1:0] MASK = '1;
`else
   localparam logic [W-1:0] MASK = '0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   led_seq_if #(.WIDTH(W)) bus ();

   led_seq #(.WIDTH(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int step_cnt = 0;

   // Counts clock cycles during which step_o is high.
   always @(negedge clk) begin
      if (bus.step_o === 1'b1) step_cnt++;
   end

   typedef struct {
      logic [1:0]   mode;
      logic         en;
      logic [W-1:0] led;
      logic         step;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [1:0] m, input logic e,
                               input logic [W-1:0] l, input logic s);
      vec_t v;
      v.mode = m; v.en = e; v.led = l; v.step = s;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One tick pulse: rise with the vector's mode/en, then fall.
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      bus.mode_i = v.mode;
      bus.en_i   = v.en;
      bus.tick_i = 1'b1;
      @(posedge clk); #1;
      check({name, "_led"},  32'(bus.led_o), 32'(v.led ^ MASK));
      check({name, "_step"}, 32'(bus.step_o), 32'(v.step));
      @(negedge clk);
      bus.tick_i = 1'b0;
      @(posedge clk); #1;
      check({name, "_step_off"}, 32'(bus.step_o), 32'(0));
   endtask

   task automatic run(input int lo, input int hi, input string tag);
      for (int i = lo; i < hi; i++)
         apply(vq[i], $sformatf("%s%0d", tag, i));
   endtask

   int ma, mb, mc, md, s0;
   vec_t cv;

   initial begin
      // Section A: rotate-left from reset, 9 rises.
      add(0,1,8'h02,1); add(0,1,8'h04,1); add(0,1,8'h08,1);
      add(0,1,8'h10,1); add(0,1,8'h20,1); add(0,1,8'h40,1);
      add(0,1,8'h80,1); add(0,1,8'h01,1); add(0,1,8'h02,1);
      ma = vq.size();
      // Section B: enter bounce (load 01), 16 rises, then enter count.
      add(2,1,8'h01,1);
      add(2,1,8'h02,1); add(2,1,8'h04,1); add(2,1,8'h08,1); add(2,1,8'h10,1);
      add(2,1,8'h20,1); add(2,1,8'h40,1); add(2,1,8'h80,1); add(2,1,8'h40,1);
      add(2,1,8'h20,1); add(2,1,8'h10,1); add(2,1,8'h08,1); add(2,1,8'h04,1);
      add(2,1,8'h02,1); add(2,1,8'h01,1); add(2,1,8'h02,1); add(2,1,8'h04,1);
      add(3,1,8'h00,1);
      mb = vq.size();
      // Section C: count wrap, disabled ticks, back to rotate-left up to 08.
      add(3,1,8'hFF,1); add(3,1,8'h00,1); add(3,1,8'h01,1);
      add(3,0,8'h01,0); add(3,0,8'h01,0);
      add(0,1,8'h01,1); add(0,1,8'h02,1); add(0,1,8'h04,1); add(0,1,8'h08,1);
      mc = vq.size();
      // Section D: after mode_i moved to 1 between ticks.
      add(1,1,8'h80,1); add(1,1,8'h40,1);
      md = vq.size();

      bus.tick_i = 1'b0; bus.en_i = 1'b0; bus.mode_i = 2'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_led",  32'(bus.led_o),  32'(8'h01 ^ MASK));
      check("reset_step", 32'(bus.step_o), 32'(0));
      @(negedge clk); rst = 1'b0;

      s0 = step_cnt;
      run(0, ma, "rol");
      check("rol_pulse_count", 32'(step_cnt - s0), 32'(9));

      run(ma, mb, "bnc");

      for (int k = 1; k <= 254; k++) begin
         cv.mode = 2'd3; cv.en = 1'b1; cv.led = W'(k); cv.step = 1'b1;
         apply(cv, $sformatf("cnt%0d", k));
      end

      s0 = step_cnt;
      run(mb, mc, "cwr");
      check("cwr_pulse_count", 32'(step_cnt - s0), 32'(7));

      // mode_i change between ticks must not act until the next rise.
      @(negedge clk); bus.mode_i = 2'd1;
      repeat (3) @(posedge clk);
      #1;
      check("modechg_hold_led",  32'(bus.led_o),  32'(8'h08 ^ MASK));
      check("modechg_hold_step", 32'(bus.step_o), 32'(0));
      run(mc, md, "ror");

      // tick_i high through reset release: no step.
      @(negedge clk); rst = 1'b1; bus.tick_i = 1'b1; bus.mode_i = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      s0 = step_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("relhigh_led",   32'(bus.led_o), 32'(8'h01 ^ MASK));
      check("relhigh_steps", 32'(step_cnt - s0), 32'(0));

      // Long high level: exactly one step.
      @(negedge clk); bus.tick_i = 1'b0;
      @(negedge clk); bus.tick_i = 1'b1;
      s0 = step_cnt;
      repeat (100) @(posedge clk);
      #1;
      check("longhigh_steps", 32'(step_cnt - s0), 32'(1));
      check("longhigh_led",   32'(bus.led_o), 32'(8'h02 ^ MASK));

      // Reset coinciding with a step event wins.
      @(negedge clk); bus.tick_i = 1'b0;
      @(negedge clk); bus.tick_i = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      check("rststep_led",  32'(bus.led_o),  32'(8'h01 ^ MASK));
      check("rststep_step", 32'(bus.step_o), 32'(0));
      @(negedge clk); rst = 1'b0; bus.tick_i = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
